// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with programmable
// wait states, byte-lane store merge and sign/zero-extended loads.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WaitInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        mem_we;

  // Request fields captured at acceptance
  logic        we_q, unsigned_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [Words];

  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            lane;
  logic [4:0]            lane_shift;
  logic [3:0]            be;
  logic [31:0]           wlanes;
  logic [31:0]           rword, rshift, load_val;
  logic                  err;

  assign widx       = addr_q[DEPTH_LOG2+1:2];
  assign lane       = addr_q[1:0];
  assign lane_shift = {lane, 3'b000};

  // Error classification, byte enables and load extraction for the latched request
  always_comb begin
    err = 1'b0;
    be  = 4'b0000;
    unique case (size_q)
      2'd0: be = 4'b0001 << lane;
      2'd1: begin
        be  = 4'b0011 << lane;
        err = addr_q[0];
      end
      2'd2: begin
        be  = 4'b1111;
        err = |addr_q[1:0];
      end
      default: err = 1'b1;
    endcase
    if ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0) err = 1'b1;

    wlanes = wdata_q << lane_shift;
    rword  = mem[widx];
    rshift = rword >> lane_shift;

    unique case (size_q)
      2'd0:    load_val = unsigned_q ? {24'd0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      2'd1:    load_val = unsigned_q ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: load_val = rword;
    endcase

    rdata_d = (err || we_q) ? 32'd0 : load_val;
    err_d   = err;
  end

  // Next-state logic for the transaction FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = StExec;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StExec;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StExec: begin
        mem_we  = we_q & ~err;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q       <= req_we;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
      end
      if (state_q == StExec) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Byte-lane merged array write; a reset arriving in EXEC cancels the commit
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a byte-addressed reference model.
// Instance 0 uses LATENCY=1, instance 1 LATENCY=3, instance 2 LATENCY=0.
module tb_dmem_responder;

  localparam int unsigned DL2      = 10;
  localparam int unsigned MemBytes = 4 << DL2;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]       rst, req_valid, req_we, req_unsigned, rsp_ready;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [2:0][1:0]  req_size;
  wire  [2:0]       req_ready, rsp_valid, rsp_err;
  wire  [2:0][31:0] rsp_rdata;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    dmem_responder #(
      .DEPTH_LOG2(DL2),
      .LATENCY   ((k == 0) ? 1 : ((k == 1) ? 3 : 0))
    ) u_dut (
      .clk         (clk),
      .rst         (rst[k]),
      .req_valid   (req_valid[k]),
      .req_ready   (req_ready[k]),
      .req_we      (req_we[k]),
      .req_addr    (req_addr[k]),
      .req_wdata   (req_wdata[k]),
      .req_size    (req_size[k]),
      .req_unsigned(req_unsigned[k]),
      .rsp_valid   (rsp_valid[k]),
      .rsp_ready   (rsp_ready[k]),
      .rsp_rdata   (rsp_rdata[k]),
      .rsp_err     (rsp_err[k])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model for instance 0: byte-addressed memory, little-endian
  logic [7:0] mb [logic [31:0]];

  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [31:0] rdata, output logic err);
    int unsigned nb;
    logic [31:0] v;
    nb    = 1 << size;
    v     = 32'd0;
    rdata = 32'd0;
    err   = (size == 2'd3) || (addr % nb != 0) || (addr >= MemBytes);
    if (err) return;
    for (int i = 0; i < nb; i++) begin
      if (we) mb[addr + i] = wdata[8*i +: 8];
      else    v[8*i +: 8]  = mb.exists(addr + i) ? mb[addr + i] : 8'h00;
    end
    if (!we) begin
      if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rdata = v;
    end
  endfunction

  // One transaction from IDLE; 'hold' = cycles of response backpressure
  task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int hold,
                     output logic [31:0] rd, output logic er);
    int m;
    rsp_ready[k]    = (hold == 0);
    req_we[k]       = we;
    req_addr[k]     = addr;
    req_wdata[k]    = wdata;
    req_size[k]     = size;
    req_unsigned[k] = uns;
    req_valid[k]    = 1'b1;
    check("req_ready_idle", req_ready[k], 1);
    @(negedge clk);
    // Scramble request inputs: they must have been sampled at acceptance
    req_valid[k]    = 1'b0;
    req_we[k]       = 1'($urandom);
    req_addr[k]     = $urandom;
    req_wdata[k]    = $urandom;
    req_size[k]     = 2'($urandom);
    req_unsigned[k] = 1'($urandom);
    m = 0;
    while (!rsp_valid[k] && m < 40) begin
      @(negedge clk);
      m++;
    end
    check("rsp_latency", m, 1 + lat_of(k));
    rd = rsp_rdata[k];
    er = rsp_err[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid[k], 1);
      check("hold_rdata", rsp_rdata[k], rd);
      check("hold_err", rsp_err[k], er);
      check("hold_req_ready", req_ready[k], 0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    check("rsp_done", rsp_valid[k], 0);
    check("ready_after_rsp", req_ready[k], 1);
  endtask

  // Instance-0 transaction checked against the model
  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input int hold, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eerr, gerr;
    model(we, addr, wdata, size, uns, erd, eerr);
    txn(0, we, addr, wdata, size, uns, hold, rd, gerr);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, 32'(gerr), 32'(eerr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, addr;
    logic        er;
    logic        bw [4];
    logic [31:0] ba [4], bd [4], bexp [4], got [4];
    logic [1:0]  bs [4];
    logic        bu [4], beer [4], gerr [4];
    int          acc [4];
    int          idx, nacc, nrsp;
    logic        adv;

    rst          = '1;
    req_valid    = '0;
    req_we       = '0;
    req_unsigned = '0;
    rsp_ready    = '1;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready[0], 0);
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_rsp_rdata", rsp_rdata[0], 0);
    check("rst_rsp_err", rsp_err[0], 0);
    rst = '0;
    #1;
    check("post_rst_ready", req_ready[0], 1);
    @(negedge clk);

    // Directed test-plan sequence
    run("sw10", 1, 32'h10, 32'hDEADBEEF, 2, 0, 0, rd);
    run("lw10", 0, 32'h10, 32'h0, 2, 0, 0, rd);
    check("tp_lw10", rd, 32'hDEADBEEF);
    run("sb11", 1, 32'h11, 32'h12, 0, 0, 0, rd);
    run("lw10b", 0, 32'h10, 32'h0, 2, 0, 0, rd);
    check("tp_merge", rd, 32'hDEAD12EF);
    run("lb13", 0, 32'h13, 32'h0, 0, 0, 0, rd);
    check("tp_lb13", rd, 32'hFFFFFFDE);
    run("lbu13", 0, 32'h13, 32'h0, 0, 1, 0, rd);
    check("tp_lbu13", rd, 32'h000000DE);
    run("lh12", 0, 32'h12, 32'h0, 1, 0, 0, rd);
    check("tp_lh12", rd, 32'hFFFFDEAD);
    run("lhu10", 0, 32'h10, 32'h0, 1, 1, 0, rd);
    check("tp_lhu10", rd, 32'h000012EF);

    // Error cases
    run("e_sh11", 1, 32'h11, 32'h0000BEEF, 1, 0, 0, rd);
    run("e_lw12", 0, 32'h12, 32'h0, 2, 0, 0, rd);
    run("e_sz3", 1, 32'h10, 32'h11111111, 3, 0, 0, rd);
    run("e_lw_oor", 0, MemBytes, 32'h0, 2, 0, 0, rd);
    run("e_sw_oor", 1, MemBytes + 32'h10, 32'h22222222, 2, 0, 0, rd);
    run("lw10c", 0, 32'h10, 32'h0, 2, 0, 0, rd);
    check("tp_unchanged", rd, 32'hDEAD12EF);

    // Backpressure for 5 cycles
    run("bp_lw10", 0, 32'h10, 32'h0, 2, 0, 5, rd);

    // Randomized traffic over a small window plus occasional out-of-range hits
    for (int w = 0; w < 16; w++) run("init", 1, 32'(w * 4), $urandom, 2, 0, 0, rd);
    for (int n = 0; n < 60; n++) begin
      addr = 32'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0:       addr = MemBytes + 32'($urandom_range(0, 63));
        1:       addr = $urandom | 32'h8000_0000;
        default: ;
      endcase
      run("rnd", 1'($urandom), addr, $urandom, 2'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, rd);
    end

    // Back-to-back with req_valid held high
    bw[0] = 1; ba[0] = 32'h24; bd[0] = $urandom; bs[0] = 2; bu[0] = 0;
    bw[1] = 0; ba[1] = 32'h24; bd[1] = 0;        bs[1] = 2; bu[1] = 0;
    bw[2] = 0; ba[2] = 32'h25; bd[2] = 0;        bs[2] = 0; bu[2] = 1;
    bw[3] = 0; ba[3] = 32'h26; bd[3] = 0;        bs[3] = 1; bu[3] = 0;
    for (int i = 0; i < 4; i++) model(bw[i], ba[i], bd[i], bs[i], bu[i], bexp[i], beer[i]);
    for (int i = 0; i < 4; i++) begin
      acc[i] = 0;
      got[i] = 32'd0;
      gerr[i] = 1'b0;
    end
    rsp_ready[0] = 1'b1;
    idx  = 0;
    nacc = 0;
    nrsp = 0;
    adv  = 1'b0;
    req_we[0] = bw[0]; req_addr[0] = ba[0]; req_wdata[0] = bd[0];
    req_size[0] = bs[0]; req_unsigned[0] = bu[0]; req_valid[0] = 1'b1;
    for (int g = 0; g < 100 && nrsp < 4; g++) begin
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 4) begin
          req_we[0] = bw[idx]; req_addr[0] = ba[idx]; req_wdata[0] = bd[idx];
          req_size[0] = bs[idx]; req_unsigned[0] = bu[idx];
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      if (rsp_valid[0]) begin
        got[nrsp]  = rsp_rdata[0];
        gerr[nrsp] = rsp_err[0];
        nrsp++;
      end
      if (req_valid[0] && req_ready[0] && nacc < 4) begin
        acc[nacc] = cyc;
        nacc++;
        adv = 1'b1;
      end
      @(negedge clk);
    end
    check("b2b_accepts", nacc, 4);
    check("b2b_responses", nrsp, 4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc[i] - acc[i-1], 3 + lat_of(0));
    for (int i = 0; i < 4; i++) begin
      check("b2b_rdata", got[i], bexp[i]);
      check("b2b_err", 32'(gerr[i]), 32'(beer[i]));
    end

    // Reset mid-transaction on LATENCY=3 and LATENCY=0 instances
    for (int k = 1; k < 3; k++) begin
      txn(k, 1, 32'h20, 32'hA5A5A5A5, 2, 0, 0, rd, er);
      check($sformatf("rm%0d_sw_err", k), 32'(er), 0);
      txn(k, 0, 32'h20, 32'h0, 2, 0, 0, rd, er);
      check($sformatf("rm%0d_lw_before", k), rd, 32'hA5A5A5A5);
      req_we[k] = 1; req_addr[k] = 32'h20; req_wdata[k] = 32'h55;
      req_size[k] = 2; req_unsigned[k] = 0; req_valid[k] = 1'b1;
      check($sformatf("rm%0d_ready", k), req_ready[k], 1);
      @(negedge clk);
      req_valid[k] = 1'b0;
      rst[k] = 1'b1;
      #1;
      check($sformatf("rm%0d_ready_in_rst", k), req_ready[k], 0);
      @(negedge clk);
      check($sformatf("rm%0d_rsp_valid", k), rsp_valid[k], 0);
      check($sformatf("rm%0d_rsp_rdata", k), rsp_rdata[k], 0);
      check($sformatf("rm%0d_rsp_err", k), rsp_err[k], 0);
      rst[k] = 1'b0;
      repeat (4) @(negedge clk);
      check($sformatf("rm%0d_idle_valid", k), rsp_valid[k], 0);
      txn(k, 0, 32'h20, 32'h0, 2, 0, 0, rd, er);
      check($sformatf("rm%0d_lw_after", k), rd, 32'hA5A5A5A5);
      check($sformatf("rm%0d_lw_err", k), 32'(er), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
